uart_max_tx: RTL and testbench

- Transmit side of the UART running-maximum path: serialises the current 8-bit running maximum back onto the TX line as a standard 8N1 or 8E1 frame.
- Sends a frame on an explicit request strobe, or automatically whenever the maximum value changes.
- Sits between the max-compare stage (source of in_max) and the external TX pin.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_baud_tick.sv | 29 ++
 rtl/uart_max_tx.sv | 124 ++++++++++++
 tb/tb_uart_max_tx.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, line levels and frame geometry.
// Used by the running-maximum transmitter and reusable by the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam logic UART_IDLE_LVL = 1'b1;
  localparam logic START_LVL     = 1'b0;
  localparam logic STOP_LVL      = 1'b1;
  localparam int   DATA_BITS     = 8;

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of
// each bit. Held at zero while i_clr is high so a frame starts on a clean bit.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  output logic o_bit_end
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr || (r_cnt == LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_bit_end = (r_cnt == LAST);

endmodule

// File: rtl/uart_max_tx.sv
// Serialises the running maximum as an 8N1/8E1 frame, on request or whenever
// the maximum differs from the last byte sent. One request can be held while busy.
module uart_max_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_EN    = 1'b0,
  parameter bit AUTO_SEND    = 1'b1
) (
  input  logic       count_clock,
  input  logic       rst_n,
  input  logic [7:0] in_max,
  input  logic       send_req,
  output logic       tx_line,
  output logic       tx_busy,
  output logic       tx_done,
  output logic [7:0] last_sent,
  output logic [2:0] dbg_state
);

  // Handshake: send_req is a single-cycle strobe with no ready; a strobe seen
  // while busy is latched into r_pending (depth one) and launched from IDLE.

  tx_state_t r_state, w_state_nxt;
  logic [7:0] r_shift, w_shift_nxt;
  logic [7:0] r_byte;
  logic [2:0] r_bit_cnt, w_bit_cnt_nxt;
  logic       r_pending;
  logic [7:0] r_last_sent;
  logic       r_tx, w_tx_nxt;
  logic       w_launch;
  logic       w_done;
  logic       w_bit_end;
  logic       w_baud_clr;

  assign w_baud_clr = (r_state == IDLE);

  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .i_clk     (count_clock),
    .i_rst_n   (rst_n),
    .i_clr     (w_baud_clr),
    .o_bit_end (w_bit_end)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_bit_cnt_nxt = r_bit_cnt;
    w_launch      = 1'b0;
    w_done        = 1'b0;
    case (r_state)
      IDLE: begin
        if (send_req || r_pending || (AUTO_SEND && (in_max != r_last_sent))) begin
          w_launch      = 1'b1;
          w_state_nxt   = START;
          w_shift_nxt   = in_max;
          w_bit_cnt_nxt = '0;
        end
      end
      START: if (w_bit_end) w_state_nxt = DATA;
      DATA: begin
        if (w_bit_end) begin
          w_shift_nxt = r_shift >> 1;
          if (r_bit_cnt == 3'(DATA_BITS - 1)) begin
            w_state_nxt = PARITY_EN ? PARITY : STOP;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
          end
        end
      end
      PARITY: if (w_bit_end) w_state_nxt = STOP;
      STOP: begin
        if (w_bit_end) begin
          w_done      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Line level is registered from the next state so the pin never glitches.
  always_comb begin
    w_tx_nxt = UART_IDLE_LVL;
    case (w_state_nxt)
      START:   w_tx_nxt = START_LVL;
      DATA:    w_tx_nxt = w_shift_nxt[0];
      PARITY:  w_tx_nxt = even_parity(r_byte);
      STOP:    w_tx_nxt = STOP_LVL;
      default: w_tx_nxt = UART_IDLE_LVL;
    endcase
  end

  always_ff @(posedge count_clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_shift     <= '0;
      r_byte      <= '0;
      r_bit_cnt   <= '0;
      r_pending   <= 1'b0;
      r_last_sent <= '0;
      r_tx        <= UART_IDLE_LVL;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_tx      <= w_tx_nxt;
      if (w_launch) begin
        r_byte    <= in_max;
        r_pending <= 1'b0;
      end else if (send_req && (r_state != IDLE)) begin
        r_pending <= 1'b1;
      end
      if (w_done) r_last_sent <= r_byte;
    end
  end

  assign tx_line   = r_tx;
  assign tx_busy   = (r_state != IDLE);
  assign tx_done   = w_done;
  assign last_sent = r_last_sent;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_uart_max_tx.sv
// Bench for uart_max_tx: three instances (8N1 manual, 8E1 manual, 8N1 auto)
// checked every cycle against a frame-level model, plus literal frame checks.
module tb_uart_max_tx;

  localparam int CPB = 4;
  localparam int ND  = 3;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] in_max   [ND];
  logic       send_req [ND];
  logic       w_tx     [ND];
  logic       w_busy   [ND];
  logic       w_done   [ND];
  logic [7:0] w_last   [ND];
  logic [2:0] w_dbg    [ND];

  uart_max_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0), .AUTO_SEND(1'b0)) u_a (
    .count_clock(clk), .rst_n(rst_n), .in_max(in_max[0]), .send_req(send_req[0]),
    .tx_line(w_tx[0]), .tx_busy(w_busy[0]), .tx_done(w_done[0]),
    .last_sent(w_last[0]), .dbg_state(w_dbg[0]));
  uart_max_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1), .AUTO_SEND(1'b0)) u_b (
    .count_clock(clk), .rst_n(rst_n), .in_max(in_max[1]), .send_req(send_req[1]),
    .tx_line(w_tx[1]), .tx_busy(w_busy[1]), .tx_done(w_done[1]),
    .last_sent(w_last[1]), .dbg_state(w_dbg[1]));
  uart_max_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0), .AUTO_SEND(1'b1)) u_c (
    .count_clock(clk), .rst_n(rst_n), .in_max(in_max[2]), .send_req(send_req[2]),
    .tx_line(w_tx[2]), .tx_busy(w_busy[2]), .tx_done(w_done[2]),
    .last_sent(w_last[2]), .dbg_state(w_dbg[2]));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // frame-level model: position within the frame, or -1 when idle
  int         m_pos  [ND] = '{-1, -1, -1};
  logic [7:0] m_byte [ND] = '{8'h00, 8'h00, 8'h00};
  logic [7:0] m_last [ND] = '{8'h00, 8'h00, 8'h00};
  bit         m_pend [ND] = '{1'b0, 1'b0, 1'b0};
  int         m_len  [ND] = '{10, 11, 10};
  bit         m_auto [ND] = '{1'b0, 1'b0, 1'b1};

  function automatic logic frame_level(input int d, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return m_byte[d][idx-1];
    if (idx == 9 && m_len[d] == 11) return ^m_byte[d];
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    for (int d = 0; d < ND; d++) begin
      if (!rst_n) begin
        m_pos[d] = -1; m_pend[d] = 1'b0; m_last[d] = 8'h00;
      end
      check($sformatf("tx%0d", d), w_tx[d],
            (m_pos[d] < 0) ? 1 : int'(frame_level(d, m_pos[d] / CPB)));
      check($sformatf("busy%0d", d), w_busy[d], (m_pos[d] >= 0) ? 1 : 0);
      check($sformatf("done%0d", d), w_done[d], (m_pos[d] == m_len[d]*CPB - 1) ? 1 : 0);
      check($sformatf("last%0d", d), w_last[d], m_last[d]);
      if (rst_n) begin
        if (m_pos[d] >= 0) begin
          if (send_req[d]) m_pend[d] = 1'b1;
          if (m_pos[d] == m_len[d]*CPB - 1) begin
            m_last[d] = m_byte[d];
            m_pos[d]  = -1;
          end else begin
            m_pos[d]++;
          end
        end else if (send_req[d] || m_pend[d] || (m_auto[d] && in_max[d] != m_last[d])) begin
          m_byte[d] = in_max[d];
          m_pos[d]  = 0;
          m_pend[d] = 1'b0;
        end
      end
    end
  end

  // driver tasks
  task automatic pulse_req(input int d);
    @(posedge clk); #1 send_req[d] = 1'b1;
    @(posedge clk); #1 send_req[d] = 1'b0;
  endtask

  // Waits for the start bit, then samples mid-bit; gap = idle negedges seen first.
  task automatic capture(input int d, input int nbits, output logic [10:0] bits,
                         output int done_c, output int gap);
    bits = '1; done_c = -1; gap = 0;
    @(negedge clk);
    while (w_tx[d] !== 1'b0 && gap < 300) begin
      @(negedge clk); gap++;
    end
    check($sformatf("launch_seen%0d", d), (gap < 300) ? 1 : 0, 1);
    for (int c = 1; c <= nbits*CPB; c++) begin
      if (c > 1) @(negedge clk);
      if (c % CPB == 2) bits[(c-1)/CPB] = w_tx[d];
      if (w_done[d]) done_c = c;
    end
  endtask

  logic [10:0] bits;
  int done_c, gap, n_ev;

  initial begin
    for (int d = 0; d < ND; d++) begin in_max[d] = 8'h00; send_req[d] = 1'b0; end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      check($sformatf("rst_tx%0d", d), w_tx[d], 1);
      check($sformatf("rst_busy%0d", d), w_busy[d], 0);
      check($sformatf("rst_last%0d", d), w_last[d], 8'h00);
    end

    // quiet idle
    n_ev = 0;
    repeat (200) begin @(negedge clk); if (w_done[0] || !w_tx[0]) n_ev++; end
    check("idle_no_frame", n_ev, 0);

    // 8N1 A5
    @(posedge clk); #1 in_max[0] = 8'hA5;
    pulse_req(0);
    capture(0, 10, bits, done_c, gap);
    check("a5_bits", bits[9:0], 10'b1101001010);
    check("a5_done_cycle", done_c, 40);
    @(negedge clk);
    check("a5_last", w_last[0], 8'hA5);

    // 8E1 07
    @(posedge clk); #1 in_max[1] = 8'h07;
    pulse_req(1);
    capture(1, 11, bits, done_c, gap);
    check("p07_bits", bits, 11'b11000001110);
    check("p07_done_cycle", done_c, 44);

    // auto send, value changes mid-frame
    @(posedge clk); #1 in_max[2] = 8'h3C;
    fork
      capture(2, 10, bits, done_c, gap);
      begin repeat (10) @(posedge clk); #1 in_max[2] = 8'h7F; end
    join
    check("auto_3c_bits", bits[9:0], 10'b1001111000);
    capture(2, 10, bits, done_c, gap);
    check("auto_7f_bits", bits[9:0], 10'b1011111110);
    check("auto_7f_gap", gap, 1);
    repeat (20) @(negedge clk);
    check("auto_no_third", w_busy[2], 0);

    // three requests during one frame yield exactly one extra frame
    n_ev = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 150; i++) begin
      send_req[0] = (i == 0 || i == 5 || i == 15 || i == 25);
      @(negedge clk);
      if (w_done[0]) n_ev++;
      @(posedge clk); #1;
    end
    send_req[0] = 1'b0;
    check("pend_frames", n_ev, 2);

    // reset in data bit 3
    pulse_req(0);
    repeat (18) @(negedge clk);
    check("pre_rst_tx", w_tx[0], 0);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_tx", w_tx[0], 1);
    check("mid_rst_busy", w_busy[0], 0);
    check("mid_rst_last", w_last[0], 8'h00);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    n_ev = 0;
    repeat (60) begin @(negedge clk); if (w_busy[0] || !w_tx[0]) n_ev++; end
    check("post_rst_idle", n_ev, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
